// File: rtl/s2p_hamming_decode_if.sv
// Serial-in bus and decoded-byte status bundle for s2p_hamming_decode.
// master: bit source / status consumer; slave: the decoder.
interface s2p_hamming_decode_if #(
  parameter int unsigned CNT_W = 8
);
  logic             bit_in;
  logic             sig_valid;
  logic [15:0]      hammingcode;
  logic [7:0]       data_out;
  logic             data_valid;
  logic [1:0]       err_corr;
  logic [1:0]       err_uncorr;
  logic             frame_abort;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  modport master (
    output bit_in, sig_valid,
    input  hammingcode, data_out, data_valid, err_corr, err_uncorr,
           frame_abort, corr_cnt, uncorr_cnt
  );

  modport slave (
    input  bit_in, sig_valid,
    output hammingcode, data_out, data_valid, err_corr, err_uncorr,
           frame_abort, corr_cnt, uncorr_cnt
  );
endinterface

// File: rtl/s2p_hamming_decode.sv
// Serial-to-parallel frame capture followed by a two-codeword extended
// Hamming(8,4) SECDED decode stage with saturating error counters.
module s2p_hamming_decode #(
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  s2p_hamming_decode_if.slave bus
);

  localparam int unsigned BCNT_W = $clog2(FRAME_W);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [FRAME_W-1:0] sr;
  logic [BCNT_W-1:0]  bit_cnt;
  logic               sig_valid_q;
  logic               dec_pend;

  logic               accept_c;
  logic               last_bit_c;
  logic               abort_c;
  logic               load_hc_c;
  logic [5:0]         dec_hi_c;
  logic [5:0]         dec_lo_c;
  logic [1:0]         corr_c;
  logic [1:0]         uncorr_c;

  // Returns {uncorr, corr, d4, d3, d2, d1} for one 8-bit codeword.
  function automatic logic [5:0] decode_cw(input logic [7:0] cw);
    logic [2:0] syn;
    logic       q;
    logic [7:0] fix;
    logic       corr;
    logic       uncorr;
    syn    = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
              cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
              cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    q      = ^cw;
    fix    = cw;
    corr   = 1'b0;
    uncorr = 1'b0;
    if (q) begin
      corr = 1'b1;
      if (syn != 3'd0) begin
        fix = cw ^ (8'd1 << 3'(syn - 3'd1));
      end
    end else if (syn != 3'd0) begin
      uncorr = 1'b1;
    end
    return {uncorr, corr, fix[6], fix[5], fix[4], fix[2]};
  endfunction

  // Adds 0..2 to a counter, clamping at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       flags);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(flags[1]) + (CNT_W+1)'(flags[0]);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign accept_c   = bus.sig_valid;
  assign last_bit_c = accept_c && (bit_cnt == BCNT_W'(FRAME_W - 1));
  // Falling qualifier mid-frame discards the partial frame.
  assign abort_c    = sig_valid_q && !bus.sig_valid && (bit_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DECODE lasts one cycle and overlaps the first bit of a following frame.
  always_comb begin
    state_nxt = state;
    load_hc_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit_c) begin
          state_nxt = ST_DECODE;
        end else if (abort_c) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DECODE: begin
        load_hc_c = 1'b1;
        state_nxt = accept_c ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shift register, bit counter and abort pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr              <= '0;
      bit_cnt         <= '0;
      sig_valid_q     <= 1'b0;
      bus.frame_abort <= 1'b0;
    end else begin
      sig_valid_q     <= bus.sig_valid;
      bus.frame_abort <= abort_c;
      if (accept_c) begin
        sr      <= {sr[FRAME_W-2:0], bus.bit_in};
        bit_cnt <= last_bit_c ? '0 : bit_cnt + BCNT_W'(1);
      end else if (abort_c) begin
        bit_cnt <= '0;
      end
    end
  end

  assign dec_hi_c = decode_cw(bus.hammingcode[15:8]);
  assign dec_lo_c = decode_cw(bus.hammingcode[7:0]);
  assign corr_c   = {dec_hi_c[4], dec_lo_c[4]};
  assign uncorr_c = {dec_hi_c[5], dec_lo_c[5]};

  // Frame capture one cycle after completion, decode the cycle after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_pend        <= 1'b0;
      bus.hammingcode <= '0;
      bus.data_out    <= '0;
      bus.data_valid  <= 1'b0;
      bus.err_corr    <= '0;
      bus.err_uncorr  <= '0;
      bus.corr_cnt    <= '0;
      bus.uncorr_cnt  <= '0;
    end else begin
      dec_pend       <= load_hc_c;
      bus.data_valid <= dec_pend;
      if (load_hc_c) begin
        bus.hammingcode <= sr;
      end
      if (dec_pend) begin
        bus.data_out   <= {dec_hi_c[3:0], dec_lo_c[3:0]};
        bus.err_corr   <= corr_c;
        bus.err_uncorr <= uncorr_c;
        bus.corr_cnt   <= sat_add(bus.corr_cnt, corr_c);
        bus.uncorr_cnt <= sat_add(bus.uncorr_cnt, uncorr_c);
      end
    end
  end

endmodule

// File: tb/tb_s2p_hamming_decode.sv
// Scoreboard bench for s2p_hamming_decode: a nearest-codeword reference
// predicts every frame; a second instance with 2-bit counters checks saturation.
module tb_s2p_hamming_decode;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SAT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   aborts_seen = 0;
  int   aborts_exp = 0;
  int   mc = 0, mu = 0;

  typedef struct {
    logic [15:0] hc;
    logic [7:0]  data;
    logic [1:0]  corr;
    logic [1:0]  uncorr;
    logic [7:0]  ccnt;
    logic [7:0]  ucnt;
    logic [1:0]  ccnt_s;
    logic [1:0]  ucnt_s;
    int          due;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  s2p_hamming_decode_if #(.CNT_W(CNT_W)) bus ();
  s2p_hamming_decode_if #(.CNT_W(SAT_W)) bus_s ();

  assign bus_s.bit_in    = bus.bit_in;
  assign bus_s.sig_valid = bus.sig_valid;

  s2p_hamming_decode #(.FRAME_W(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  s2p_hamming_decode #(.FRAME_W(16), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_s.slave)
  );

  function automatic logic [7:0] enc(input logic [3:0] n);
    logic [7:0] cw;
    cw[2] = n[0];
    cw[4] = n[1];
    cw[5] = n[2];
    cw[6] = n[3];
    cw[0] = n[0] ^ n[1] ^ n[3];
    cw[1] = n[0] ^ n[2] ^ n[3];
    cw[3] = n[1] ^ n[2] ^ n[3];
    cw[7] = ^cw[6:0];
    return cw;
  endfunction

  // Nearest valid codeword; returns {uncorr, corr, nibble}.
  function automatic logic [5:0] ref_dec(input logic [7:0] cw);
    int         best;
    logic [3:0] bn;
    best = 9;
    bn   = 4'd0;
    for (int k = 0; k < 16; k++) begin
      int d;
      d = $countones(cw ^ enc(4'(k)));
      if (d < best) begin
        best = d;
        bn   = 4'(k);
      end
    end
    if (best == 0) return {2'b00, bn};
    if (best == 1) return {2'b01, bn};
    return {2'b10, cw[6], cw[5], cw[4], cw[2]};
  endfunction

  task automatic push_expect(input logic [15:0] w);
    logic [5:0] hi, lo;
    exp_t       e;
    hi = ref_dec(w[15:8]);
    lo = ref_dec(w[7:0]);
    mc = mc + int'(hi[4]) + int'(lo[4]);
    mu = mu + int'(hi[5]) + int'(lo[5]);
    e.hc     = w;
    e.data   = {hi[3:0], lo[3:0]};
    e.corr   = {hi[4], lo[4]};
    e.uncorr = {hi[5], lo[5]};
    e.ccnt   = 8'((mc > 255) ? 255 : mc);
    e.ucnt   = 8'((mu > 255) ? 255 : mu);
    e.ccnt_s = 2'((mc > 3) ? 3 : mc);
    e.ucnt_s = 2'((mu > 3) ? 3 : mu);
    e.due    = cyc + 3;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and check any decoder output there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.frame_abort === 1'b1) aborts_seen++;
    if (bus.data_valid !== 1'b0) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: data_valid=%b with nothing pending at cycle %0d", bus.data_valid, cyc);
      end else begin
        e = sb.pop_front();
        tests++;
        if (cyc !== e.due) begin
          fails++;
          $display("FAIL valid_latency: data_valid at cycle %0d, required %0d", cyc, e.due);
        end
        tests++;
        if (bus.hammingcode !== e.hc) begin
          fails++;
          $display("FAIL hammingcode: got %h, required %h", bus.hammingcode, e.hc);
        end
        tests++;
        if ({bus.data_out, bus.err_corr, bus.err_uncorr} !== {e.data, e.corr, e.uncorr}) begin
          fails++;
          $display("FAIL decode(%h): data/corr/uncorr got %h/%b/%b, required %h/%b/%b",
                   e.hc, bus.data_out, bus.err_corr, bus.err_uncorr, e.data, e.corr, e.uncorr);
        end
        tests++;
        if ({bus.corr_cnt, bus.uncorr_cnt} !== {e.ccnt, e.ucnt}) begin
          fails++;
          $display("FAIL counters: corr/uncorr got %0d/%0d, required %0d/%0d",
                   bus.corr_cnt, bus.uncorr_cnt, e.ccnt, e.ucnt);
        end
        tests++;
        if ({bus_s.data_valid, bus_s.data_out, bus_s.corr_cnt, bus_s.uncorr_cnt} !==
            {1'b1, e.data, e.ccnt_s, e.ucnt_s}) begin
          fails++;
          $display("FAIL sat_instance: valid/data/corr/uncorr got %b/%h/%0d/%0d, required 1/%h/%0d/%0d",
                   bus_s.data_valid, bus_s.data_out, bus_s.corr_cnt, bus_s.uncorr_cnt,
                   e.data, e.ccnt_s, e.ucnt_s);
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic b);
    tick();
    bus.sig_valid = v;
    bus.bit_in    = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) drive(1'b1, w[i]);
    push_expect(w);
  endtask

  task automatic check_drained(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) drive(1'b0, 1'b0);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d frames still pending, required 0", name, sb.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if ({bus.hammingcode, bus.data_out, bus.data_valid, bus.err_corr, bus.err_uncorr,
         bus.frame_abort, bus.corr_cnt, bus.uncorr_cnt, bus_s.corr_cnt, bus_s.uncorr_cnt} !== '0) begin
      fails++;
      $display("FAIL %s: hc=%h data=%h dv=%b corr=%b uncorr=%b abort=%b cnt=%0d/%0d, required all 0",
               name, bus.hammingcode, bus.data_out, bus.data_valid, bus.err_corr, bus.err_uncorr,
               bus.frame_abort, bus.corr_cnt, bus.uncorr_cnt);
    end
  endtask

  task automatic test_reset();
    bus.sig_valid = 1'b0;
    bus.bit_in    = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset_state");
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_clean();
    send_frame(16'hD22D);
    idle(6);
    check_drained("clean");
    tests++;
    if ({bus.data_out, bus.err_corr, bus.err_uncorr, bus.data_valid} !== {8'hA5, 2'b00, 2'b00, 1'b0}) begin
      fails++;
      $display("FAIL clean_hold: data=%h corr=%b uncorr=%b dv=%b, required a5/00/00/0",
               bus.data_out, bus.err_corr, bus.err_uncorr, bus.data_valid);
    end
  endtask

  task automatic test_single_error();
    send_frame(16'hD23D);
    idle(4);
    tests++;
    if ({bus.data_out, bus.err_corr, bus.corr_cnt} !== {8'hA5, 2'b01, 8'd1}) begin
      fails++;
      $display("FAIL single_low: data=%h corr=%b corr_cnt=%0d, required a5/01/1",
               bus.data_out, bus.err_corr, bus.corr_cnt);
    end
    send_frame(16'h522D);
    idle(4);
    tests++;
    if ({bus.data_out, bus.err_corr, bus.err_uncorr} !== {8'hA5, 2'b10, 2'b00}) begin
      fails++;
      $display("FAIL single_parity_hi: data=%h corr=%b uncorr=%b, required a5/10/00",
               bus.data_out, bus.err_corr, bus.err_uncorr);
    end
    check_drained("single");
  endtask

  task automatic test_double_error();
    send_frame(16'hD12D);
    idle(4);
    tests++;
    if ({bus.err_uncorr, bus.uncorr_cnt, bus.data_out[3:0]} !== {2'b10, 8'd1, 4'h5}) begin
      fails++;
      $display("FAIL double_hi: uncorr=%b uncorr_cnt=%0d data_lo=%h, required 10/1/5",
               bus.err_uncorr, bus.uncorr_cnt, bus.data_out[3:0]);
    end
    check_drained("double");
  endtask

  task automatic test_back_to_back();
    send_frame(16'hD22D);
    send_frame(16'h0000);
    idle(4);
    check_drained("b2b");
    tests++;
    if (bus.data_out !== 8'h00) begin
      fails++;
      $display("FAIL b2b_last: data=%h, required 00", bus.data_out);
    end
  endtask

  task automatic test_abort();
    logic [15:0] hc_before;
    hc_before = bus.hammingcode;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'($urandom_range(1)));
    aborts_exp++;
    idle(4);
    tests++;
    if (aborts_seen !== aborts_exp) begin
      fails++;
      $display("FAIL abort_pulse: saw %0d aborts, required %0d", aborts_seen, aborts_exp);
    end
    tests++;
    if (bus.hammingcode !== hc_before) begin
      fails++;
      $display("FAIL abort_hc: hammingcode %h, required %h", bus.hammingcode, hc_before);
    end
    send_frame(16'hD22D);
    idle(4);
    check_drained("abort");
    tests++;
    if (bus.data_out !== 8'hA5) begin
      fails++;
      $display("FAIL abort_recover: data=%h, required a5", bus.data_out);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      send_frame(16'($urandom));
      if ($urandom_range(1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(4);
    check_drained("random");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    tick();
    rst = 1'b1;
    bus.sig_valid = 1'b0;
    repeat (2) tick();
    check_all_zero("reset_mid");
    rst = 1'b0;
    mc = 0;
    mu = 0;
    idle(4);
    check_all_zero("reset_mid_after");
    tests++;
    if (aborts_seen !== aborts_exp) begin
      fails++;
      $display("FAIL reset_no_abort: saw %0d aborts, required %0d", aborts_seen, aborts_exp);
    end
    send_frame(16'hD22D);
    idle(4);
    check_drained("reset_mid");
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 5; k++) send_frame(16'hD23D);
    idle(4);
    check_drained("sat");
    tests++;
    if ({bus_s.corr_cnt, bus.corr_cnt} !== {2'd3, 8'd5}) begin
      fails++;
      $display("FAIL saturation: sat corr_cnt=%0d wide corr_cnt=%0d, required 3/5",
               bus_s.corr_cnt, bus.corr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_double_error();
    test_back_to_back();
    test_abort();
    test_random();
    test_reset_mid();
    test_saturation();
    tests++;
    if (aborts_seen !== aborts_exp) begin
      fails++;
      $display("FAIL abort_total: saw %0d aborts, required %0d", aborts_seen, aborts_exp);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/s2p_hamming_decode.md
Name: s2p_hamming_decode

Overview:
- Receive-side counterpart of the transmit chain's P2S converter and Hamming encoder.
- Collects a serial bit stream, qualified by sig_valid, into 16-bit frames sent MSB first.
- Decodes each frame as two extended Hamming(8,4) SECDED codewords and outputs the recovered byte with error status.
- Sits behind the FSK demodulator / bit-recovery stage; data_out drives LEDs for comparison with the transmitter's data_out.

Parameters:
- FRAME_W, 16, bits per frame (fixed; other values unsupported).
- CNT_W, 8, width of the saturating error counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial code bit, sampled only when sig_valid=1.
- sig_valid  input  1  bit qualifier; one bit accepted per cycle while high.
- hammingcode  output  16  last complete raw frame received.
- data_out  output  8  decoded/corrected byte, held until the next frame.
- data_valid  output  1  one-cycle pulse when data_out/err flags update.
- err_corr  output  2  [1]=upper nibble, [0]=lower nibble: single error corrected.
- err_uncorr  output  2  per nibble: double error detected, not corrected.
- frame_abort  output  1  one-cycle pulse when a partial frame is discarded.
- corr_cnt  output  CNT_W  saturating count of corrected nibbles.
- uncorr_cnt  output  CNT_W  saturating count of uncorrectable nibbles.

Behaviour:
- Reset: all outputs 0; bit count 0; shift register 0. Reset mid-frame discards the partial frame with no frame_abort pulse.
- Shift stage:
  - Each cycle with sig_valid=1: sr <= {sr[14:0], bit_in}; bit_cnt++.
  - On the 16th bit, the full word is copied to hammingcode the next cycle and bit_cnt returns to 0.
  - Back-to-back frames with sig_valid continuously high are supported, with no dead cycle: bit 17 starts the next frame.
- Abort rule: sig_valid falling (1 then 0) while bit_cnt is 1..15 clears bit_cnt and pulses frame_abort the next cycle. Nothing else changes.
- Codeword layout: hammingcode[15:8] carries data[7:4]; hammingcode[7:0] carries data[3:0]. Within each byte cw:
  - cw0=p1, cw1=p2, cw2=d1, cw3=p4, cw4=d2, cw5=d3, cw6=d4, cw7=overall even parity over cw[6:0].
  - Nibble n maps as d1=n0, d2=n1, d3=n2, d4=n3.
- Decode per codeword:
  - Syndrome: s1=cw0^cw2^cw4^cw6, s2=cw1^cw2^cw5^cw6, s4=cw3^cw4^cw5^cw6, s={s4,s2,s1}; q=^cw[7:0].
  - s=0, q=0: clean.
  - q=1, s!=0: flip cw[s-1], err_corr=1.
  - q=1, s=0: parity bit in error; data unaffected, err_corr=1.
  - q=0, s!=0: err_uncorr=1; data_out nibble = raw d4..d1, uncorrected.
- Latency: last bit sampled at edge N → hammingcode valid after N+1 → data_out, err flags and data_valid valid after N+2. A new frame completing every 16 cycles never collides.
- Flags: err_corr and err_uncorr are held with data_out until the next data_valid.
- Counters: incremented by the number of flagged nibbles (0–2) on each data_valid; saturate at all-ones; cleared only by rst.
- State machine: IDLE (bit_cnt=0), SHIFT (1..15), DECODE (one cycle after frame complete), then back to IDLE or SHIFT. DECODE overlaps SHIFT of the next frame, so decode is a separate pipeline register, not a stall.

Test Plan:
- Clean frame: shift 0xD22D MSB first with sig_valid high for 16 cycles → data_out=0xA5, err_corr=00, err_uncorr=00, data_valid 2 cycles after last bit.
- Single error: 0xD22D with bit 4 flipped (0xD23D) → data_out=0xA5, err_corr=01, corr_cnt=1. Flip bit 15 only (0x522D) → data_out=0xA5, err_corr=10.
- Double error: 0xD22D with bits 9 and 8 flipped (0xD12D) → err_uncorr=10, uncorr_cnt=1, lower nibble of data_out=0x5.
- Back-to-back frames: 0xD22D then 0x0000, 32 continuous valid cycles → two data_valid pulses 16 cycles apart, data_out 0xA5 then 0x00.
- Abort: sig_valid high 7 cycles then low → frame_abort pulse, no data_valid; a following clean 0xD22D frame decodes to 0xA5.
- Reset and saturation: assert rst mid-frame → all outputs 0, no pulses. With CNT_W=2, feed 5 single-error frames → corr_cnt holds at 3.
